// File: rtl/button_input.sv
// Four-button front end: 2-flop sync, optional debounce (`BUTTON_DEBOUNCE_EN`),
// rising-edge detect and a one-hot pending request held until the game tick.
module button_input #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_btn,
    input  logic       i_tick,
    output logic       o_up,
    output logic       o_down,
    output logic       o_left,
    output logic       o_right,
    output logic       o_any
);

    if (DEBOUNCE_BITS < 1 || DEBOUNCE_BITS > 24) begin : g_param_check
        $error("button_input: DEBOUNCE_BITS must be within 1..24");
    end

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] stable_q;
    logic [3:0] stable_d;
    logic [3:0] stable_prev_q;
    logic [3:0] press;
    logic [3:0] req_q;
    logic [3:0] req_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef BUTTON_DEBOUNCE_EN
    logic [DEBOUNCE_BITS-1:0] cnt_q [4];
    logic [DEBOUNCE_BITS-1:0] cnt_d [4];

    // A disagreeing input must survive a full counter sweep before it is accepted;
    // any return to agreement restarts the count, so the counter never wraps.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == {DEBOUNCE_BITS{1'b1}}) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        stable_d = sync2_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q      <= '0;
            stable_prev_q <= '0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
        end
    end

    assign press = stable_q & ~stable_prev_q;

    // A new press beats a coincident tick so a press landing on the tick is not lost.
    always_comb begin
        req_d = req_q;
        if (|press) begin
            if (press[3]) begin
                req_d = 4'b1000;
            end else if (press[2]) begin
                req_d = 4'b0100;
            end else if (press[1]) begin
                req_d = 4'b0010;
            end else begin
                req_d = 4'b0001;
            end
        end else if (i_tick) begin
            req_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign o_up    = req_q[3];
    assign o_down  = req_q[2];
    assign o_left  = req_q[1];
    assign o_right = req_q[0];
    assign o_any   = |req_q;

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with DEBOUNCE_BITS=4; expectations follow
// whichever build (`BUTTON_DEBOUNCE_EN` defined or not) is compiled.
module tb_button_input;

    // Edges from the first edge sampling a raw rise until the request is visible:
    // 2 sync + 2^4 debounce (stable rises on the 16th edge after sync) + 1 for req.
`ifdef BUTTON_DEBOUNCE_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 3;
`endif

    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] UP    = 5'b10001;
    localparam logic [4:0] DOWN  = 5'b01001;
    localparam logic [4:0] LEFT  = 5'b00101;
    localparam logic [4:0] RIGHT = 5'b00011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       tick = 1'b0;
    logic       o_up, o_down, o_left, o_right, o_any;
    logic [4:0] outs;

    int pass_cnt  = 0;
    int total_cnt = 0;

    assign outs = {o_up, o_down, o_left, o_right, o_any};

    button_input #(.DEBOUNCE_BITS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn),
        .i_tick (tick),
        .o_up   (o_up),
        .o_down (o_down),
        .o_left (o_left),
        .o_right(o_right),
        .o_any  (o_any)
    );

    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 4'b0000;
        tick = 1'b0;
        repeat (3) edge1();
        total_cnt++;
        if (outs !== NONE) $display("FAIL reset_hold: got %b expected %b", outs, NONE);
        else pass_cnt++;
        rst = 1'b0;
        edge1();
        total_cnt++;
        if (outs !== NONE) $display("FAIL reset_release: got %b expected %b", outs, NONE);
        else pass_cnt++;
    endtask

    task automatic test_single_press();
        logic [4:0] exp;
        btn = 4'b1000;
        for (int k = 0; k < 40; k++) begin
            edge1();
            exp = (k >= LAT) ? UP : NONE;
            total_cnt++;
            if (outs !== exp) $display("FAIL single_press k=%0d: got %b expected %b", k, outs, exp);
            else pass_cnt++;
        end
        tick = 1'b1;
        edge1();
        tick = 1'b0;
        total_cnt++;
        if (outs !== NONE) $display("FAIL tick_clear: got %b expected %b", outs, NONE);
        else pass_cnt++;
        for (int k = 0; k < 10; k++) begin
            edge1();
            total_cnt++;
            if (outs !== NONE) $display("FAIL held_no_repeat k=%0d: got %b expected %b", k, outs, NONE);
            else pass_cnt++;
        end
        btn = 4'b0000;
        repeat (LAT + 2) edge1();
        total_cnt++;
        if (outs !== NONE) $display("FAIL release_quiet: got %b expected %b", outs, NONE);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        logic [4:0] exp;
        for (int k = 0; k < 60; k++) begin
            btn = (((k / 5) % 2) == 0) ? 4'b0010 : 4'b0000;
            edge1();
`ifdef BUTTON_DEBOUNCE_EN
            exp = NONE;
`else
            exp = (k >= LAT) ? LEFT : NONE;
`endif
            total_cnt++;
            if (outs !== exp) $display("FAIL bounce k=%0d: got %b expected %b", k, outs, exp);
            else pass_cnt++;
        end
        btn = 4'b0000;
        repeat (LAT + 2) edge1();
        tick = 1'b1;
        edge1();
        tick = 1'b0;
        total_cnt++;
        if (outs !== NONE) $display("FAIL bounce_cleanup: got %b expected %b", outs, NONE);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        logic [4:0] exp;
        btn = 4'b1001;
        repeat (LAT + 2) edge1();
        total_cnt++;
        if (outs !== UP) $display("FAIL prio_up_over_right: got %b expected %b", outs, UP);
        else pass_cnt++;
        btn = 4'b0000;
        repeat (LAT + 2) edge1();
        total_cnt++;
        if (outs !== UP) $display("FAIL prio_release_holds: got %b expected %b", outs, UP);
        else pass_cnt++;
        btn = 4'b0100;
        for (int k = 0; k <= LAT + 2; k++) begin
            edge1();
            exp = (k >= LAT) ? DOWN : UP;
            total_cnt++;
            if (outs !== exp) $display("FAIL prio_overwrite k=%0d: got %b expected %b", k, outs, exp);
            else pass_cnt++;
        end
        tick = 1'b1;
        edge1();
        tick = 1'b0;
        btn = 4'b0000;
        repeat (LAT + 2) edge1();
        total_cnt++;
        if (outs !== NONE) $display("FAIL prio_cleanup: got %b expected %b", outs, NONE);
        else pass_cnt++;
    endtask

    task automatic test_coincident();
        logic [4:0] exp;
        btn = 4'b0001;
        repeat (LAT + 2) edge1();
        total_cnt++;
        if (outs !== RIGHT) $display("FAIL coinc_setup: got %b expected %b", outs, RIGHT);
        else pass_cnt++;
        btn = 4'b0000;
        repeat (LAT + 2) edge1();
        btn = 4'b0010;
        // The tick is high only for edge LAT, the same edge that stores the left press.
        for (int k = 0; k <= LAT + 10; k++) begin
            edge1();
            exp = (k >= LAT) ? LEFT : RIGHT;
            total_cnt++;
            if (outs !== exp) $display("FAIL coinc k=%0d: got %b expected %b", k, outs, exp);
            else pass_cnt++;
            tick = (k == LAT - 1);
        end
        tick = 1'b1;
        edge1();
        tick = 1'b0;
        total_cnt++;
        if (outs !== NONE) $display("FAIL coinc_next_tick: got %b expected %b", outs, NONE);
        else pass_cnt++;
        btn = 4'b0000;
        repeat (LAT + 2) edge1();
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        btn = 4'b0001;
        repeat (LAT + 2) edge1();
        total_cnt++;
        if (outs !== RIGHT) $display("FAIL rmid_setup: got %b expected %b", outs, RIGHT);
        else pass_cnt++;
        btn = 4'b0101;
        repeat (2) edge1();
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (outs !== NONE) $display("FAIL rmid_async_clear: got %b expected %b", outs, NONE);
        else pass_cnt++;
        btn = 4'b0000;
        repeat (2) edge1();
        rst = 1'b0;
        for (int k = 0; k < LAT + 5; k++) begin
            edge1();
            total_cnt++;
            if (outs !== NONE) $display("FAIL rmid_no_request k=%0d: got %b expected %b", k, outs, NONE);
            else pass_cnt++;
        end
        rst = 1'b1;
        btn = 4'b1000;
        repeat (3) edge1();
        rst = 1'b0;
        for (int k = 0; k < LAT + 15; k++) begin
            edge1();
            exp = (k >= LAT) ? UP : NONE;
            total_cnt++;
            if (outs !== exp) $display("FAIL held_through_reset k=%0d: got %b expected %b", k, outs, exp);
            else pass_cnt++;
        end
        tick = 1'b1;
        edge1();
        tick = 1'b0;
        for (int k = 0; k < 10; k++) begin
            edge1();
            total_cnt++;
            if (outs !== NONE) $display("FAIL held_through_reset_once k=%0d: got %b expected %b", k, outs, NONE);
            else pass_cnt++;
        end
        btn = 4'b0000;
        repeat (LAT + 2) edge1();
    endtask

    task automatic test_short_pulse();
        logic [4:0] exp;
        btn = 4'b0100;
        edge1();
        btn = 4'b0000;
        total_cnt++;
        if (outs !== NONE) $display("FAIL pulse k=0: got %b expected %b", outs, NONE);
        else pass_cnt++;
        for (int k = 1; k < LAT + 6; k++) begin
            edge1();
`ifdef BUTTON_DEBOUNCE_EN
            exp = NONE;
`else
            exp = (k >= 3) ? DOWN : NONE;
`endif
            total_cnt++;
            if (outs !== exp) $display("FAIL pulse k=%0d: got %b expected %b", k, outs, exp);
            else pass_cnt++;
        end
        tick = 1'b1;
        edge1();
        tick = 1'b0;
        total_cnt++;
        if (outs !== NONE) $display("FAIL pulse_cleanup: got %b expected %b", outs, NONE);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_priority();
        test_coincident();
        test_reset_mid();
        test_short_pulse();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
